// File: rtl/align_feeder.sv
// align_feeder: host-side sequencer for an N-PE alignment systolic array.
// Gathers a query, then drives clear / preload / compute while streaming reference bases.
module align_feeder #(
  parameter int N         = 5,
  parameter int REF_LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [REF_LEN_W-1:0] ref_len,
  input  logic                 q_valid,
  output logic                 q_ready,
  input  logic [1:0]           q_base,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [1:0]           r_base,
  output logic                 clear_en,
  output logic                 read_load_en,
  output logic [N-1:0][1:0]    read_base_out,
  output logic                 compute_en,
  output logic                 ref_valid_out,
  output logic [1:0]           ref_out,
  output logic                 busy,
  output logic                 done
);

  localparam int QW = $clog2(N + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD_Q,
    PRELOAD,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [REF_LEN_W-1:0] len_q;
  logic [REF_LEN_W-1:0] rCnt_q;
  logic [QW-1:0]        qCnt_q;
  logic [QW-1:0]        dCnt_q;
  logic [N-1:0][1:0]    qBuf_q;

  logic qHandshake, rHandshake, qLast, rLast, drainLast;

  assign qHandshake = (state_q == LOAD_Q) && q_valid;
  assign rHandshake = (state_q == STREAM) && r_valid;
  assign qLast      = qHandshake && (qCnt_q == QW'(N - 1));
  assign rLast      = rHandshake && ((rCnt_q + REF_LEN_W'(1)) == len_q);
  // Only consulted in DRAIN, which is unreachable when N==1.
  assign drainLast  = (dCnt_q == QW'(N - 2));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = LOAD_Q;
      LOAD_Q:  if (qLast) state_d = PRELOAD;
      PRELOAD: state_d = (len_q != '0) ? STREAM : DONE;
      STREAM:  if (rLast) state_d = (N == 1) ? DONE : DRAIN;
      DRAIN:   if (drainLast) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clear_en      = 1'b0;
    q_ready       = 1'b0;
    read_load_en  = 1'b0;
    compute_en    = 1'b0;
    r_ready       = 1'b0;
    ref_valid_out = 1'b0;
    ref_out       = 2'b00;
    done          = 1'b0;
    case (state_q)
      CLEAR:   clear_en = 1'b1;
      LOAD_Q:  q_ready = 1'b1;
      PRELOAD: read_load_en = 1'b1;
      STREAM: begin
        compute_en    = 1'b1;
        r_ready       = 1'b1;
        ref_valid_out = r_valid;
        ref_out       = r_valid ? r_base : 2'b00;
      end
      DRAIN:   compute_en = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
    busy = (state_q != IDLE);
  end

  // The query buffer survives CLEAR and job end; only LOAD_Q handshakes overwrite it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q  <= '0;
      rCnt_q <= '0;
      qCnt_q <= '0;
      dCnt_q <= '0;
      qBuf_q <= '0;
    end else begin
      if ((state_q == IDLE) && start) begin
        len_q  <= ref_len;
        qCnt_q <= '0;
        rCnt_q <= '0;
      end
      if (qHandshake) begin
        qBuf_q[qCnt_q] <= q_base;
        qCnt_q         <= qCnt_q + QW'(1);
      end
      if (rHandshake) rCnt_q <= rCnt_q + REF_LEN_W'(1);
      dCnt_q <= (state_q == DRAIN) ? dCnt_q + QW'(1) : '0;
    end
  end

  assign read_base_out = qBuf_q;

endmodule
